// File: rtl/branch_predict_2lvl.sv
// branch_predict_2lvl: direct-mapped PHT of saturating counters plus a tagged BTB.
// Lookup returns a registered taken/target/hit prediction one cycle later.
// Update port trains the counters and, on taken branches, the BTB.
// Optional feature: define BPRED_GSHARE_EN to XOR a global history register into
// the PHT index (gshare). Without it the PHT is indexed by PC bits only (bimodal).
module branch_predict_2lvl #(
    parameter int PHT_ENTRIES = 256,
    parameter int BTB_ENTRIES = 64,
    parameter int CTR_WIDTH   = 2,
    parameter int GHR_WIDTH   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lookup_valid_i,
    input  logic        stall_i,
    input  logic [31:0] pc_i,
    output logic        pred_valid_o,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    output logic        btb_hit_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i
);

    localparam int PHT_IDX_W = $clog2(PHT_ENTRIES);
    localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W     = 30 - BTB_IDX_W;

    // Weakly not-taken: 2^(CTR_WIDTH-1)-1
    localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = {CTR_WIDTH{1'b1}};
    localparam logic [CTR_WIDTH-1:0] CTR_MIN  = {CTR_WIDTH{1'b0}};
    localparam logic [CTR_WIDTH-1:0] CTR_ONE  = CTR_WIDTH'(1);

    // Storage lives in flops so that reset can clear it asynchronously.
    logic [CTR_WIDTH-1:0] pht_r       [PHT_ENTRIES];
    logic                 btb_valid_r [BTB_ENTRIES];
    logic [TAG_W-1:0]     btb_tag_r   [BTB_ENTRIES];
    logic [29:0]          btb_tgt_r   [BTB_ENTRIES];

    logic                 pred_valid_r;
    logic                 pred_taken_r;
    logic [31:0]          pred_target_r;
    logic                 btb_hit_r;

    logic [PHT_IDX_W-1:0] hist_s;
    logic [PHT_IDX_W-1:0] rd_idx_s;
    logic [PHT_IDX_W-1:0] upd_idx_s;
    logic [BTB_IDX_W-1:0] rd_set_s;
    logic [BTB_IDX_W-1:0] upd_set_s;
    logic [CTR_WIDTH-1:0] rd_ctr_s;
    logic [CTR_WIDTH-1:0] upd_ctr_s;
    logic [CTR_WIDTH-1:0] ctr_next_s;
    logic                 rd_hit_s;
    logic                 unused_bits_s;

`ifdef BPRED_GSHARE_EN
    logic [GHR_WIDTH-1:0] ghr_r;

    // Global history shifts at resolution; both lookup and update this cycle see the old value.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ghr_r <= {GHR_WIDTH{1'b0}};
        end else if (upd_valid_i) begin
            ghr_r <= GHR_WIDTH'({ghr_r, upd_taken_i});
        end
    end

    assign hist_s = PHT_IDX_W'(ghr_r);
`else
    localparam int unused_ghr_width = GHR_WIDTH;
    assign hist_s = {PHT_IDX_W{1'b0}};
`endif

    // Word-aligned PCs: the two low bits of every address carry no information.
    assign unused_bits_s = ^{pc_i[1:0], upd_pc_i[1:0], upd_target_i[1:0]};

    assign rd_idx_s  = pc_i[PHT_IDX_W+1:2] ^ hist_s;
    assign upd_idx_s = upd_pc_i[PHT_IDX_W+1:2] ^ hist_s;
    assign rd_set_s  = pc_i[BTB_IDX_W+1:2];
    assign upd_set_s = upd_pc_i[BTB_IDX_W+1:2];
    assign rd_ctr_s  = pht_r[rd_idx_s];
    assign upd_ctr_s = pht_r[upd_idx_s];
    assign rd_hit_s  = btb_valid_r[rd_set_s] && (btb_tag_r[rd_set_s] == pc_i[31:BTB_IDX_W+2]);

    // Saturating counter step for the branch being resolved.
    always_comb begin
        ctr_next_s = upd_ctr_s;
        if (upd_taken_i) begin
            if (upd_ctr_s != CTR_MAX) begin
                ctr_next_s = upd_ctr_s + CTR_ONE;
            end else begin
                ctr_next_s = upd_ctr_s;
            end
        end else begin
            if (upd_ctr_s != CTR_MIN) begin
                ctr_next_s = upd_ctr_s - CTR_ONE;
            end else begin
                ctr_next_s = upd_ctr_s;
            end
        end
    end

    // PHT training; a same-cycle lookup already sampled the old counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_r[i] <= CTR_INIT;
            end
        end else if (upd_valid_i) begin
            pht_r[upd_idx_s] <= ctr_next_s;
        end
    end

    // BTB allocation on taken branches only; direct-mapped so it overwrites.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid_r[i] <= 1'b0;
                btb_tag_r[i]   <= {TAG_W{1'b0}};
                btb_tgt_r[i]   <= 30'd0;
            end
        end else if (upd_valid_i && upd_taken_i) begin
            btb_valid_r[upd_set_s] <= 1'b1;
            btb_tag_r[upd_set_s]   <= upd_pc_i[31:BTB_IDX_W+2];
            btb_tgt_r[upd_set_s]   <= upd_target_i[31:2];
        end
    end

    // Registered prediction; stall freezes everything, an idle cycle drops only valid.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pred_valid_r  <= 1'b0;
            pred_taken_r  <= 1'b0;
            pred_target_r <= 32'd0;
            btb_hit_r     <= 1'b0;
        end else if (!stall_i) begin
            if (lookup_valid_i) begin
                pred_valid_r  <= 1'b1;
                pred_taken_r  <= rd_ctr_s[CTR_WIDTH-1] && rd_hit_s;
                pred_target_r <= {btb_tgt_r[rd_set_s], 2'b00};
                btb_hit_r     <= rd_hit_s;
            end else begin
                pred_valid_r  <= 1'b0;
            end
        end
    end

    assign pred_valid_o  = pred_valid_r;
    assign pred_taken_o  = pred_taken_r;
    assign pred_target_o = pred_target_r;
    assign btb_hit_o     = btb_hit_r;

endmodule

// File: tb/tb_branch_predict_2lvl.sv
// Directed self-checking bench for branch_predict_2lvl with default parameters
// (PHT 256, BTB 64, 2-bit counters). Inputs change on the falling edge and
// outputs are checked on the falling edge after the capturing rising edge.
// With BPRED_GSHARE_EN defined, a gshare history scenario runs instead.
module tb_branch_predict_2lvl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        lookup_valid_i;
    logic        stall_i;
    logic [31:0] pc_i;
    logic        pred_valid_o;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic        btb_hit_o;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;

    int checks = 0;
    int errors = 0;

    branch_predict_2lvl dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .lookup_valid_i (lookup_valid_i),
        .stall_i        (stall_i),
        .pc_i           (pc_i),
        .pred_valid_o   (pred_valid_o),
        .pred_taken_o   (pred_taken_o),
        .pred_target_o  (pred_target_o),
        .btb_hit_o      (btb_hit_o),
        .upd_valid_i    (upd_valid_i),
        .upd_pc_i       (upd_pc_i),
        .upd_taken_i    (upd_taken_i),
        .upd_target_i   (upd_target_i)
    );

    // Free-running 10-unit clock.
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        upd_valid_i  = 1'b1;
        upd_pc_i     = pc;
        upd_taken_i  = taken;
        upd_target_i = tgt;
        @(negedge clk_i);
        upd_valid_i  = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc);
        lookup_valid_i = 1'b1;
        pc_i           = pc;
        @(negedge clk_i);
        lookup_valid_i = 1'b0;
    endtask

    task automatic check_pred(input string tag, input logic valid, input logic hit, input logic taken);
        check_eq({tag, "_valid"}, {31'd0, pred_valid_o}, {31'd0, valid});
        check_eq({tag, "_hit"},   {31'd0, btb_hit_o},    {31'd0, hit});
        check_eq({tag, "_taken"}, {31'd0, pred_taken_o}, {31'd0, taken});
    endtask

    initial begin
        rst_i          = 1'b0;
        lookup_valid_i = 1'b0;
        stall_i        = 1'b0;
        pc_i           = 32'd0;
        upd_valid_i    = 1'b0;
        upd_pc_i       = 32'd0;
        upd_taken_i    = 1'b0;
        upd_target_i   = 32'd0;
        #1;
        check_pred("rst", 1'b0, 1'b0, 1'b0);
        check_eq("rst_target", pred_target_o, 32'h0000_0000);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);

`ifdef BPRED_GSHARE_EN
        // Eight taken updates at pc 0x40 drive GHR to 0xFF without touching idx 0x00/0xFF.
        for (int i = 0; i < 8; i++) upd(32'h0000_0040, 1'b1, 32'h0000_0800);
        // With GHR=0xFF pc 0x1000 maps to idx 0xFF: 01 -> 10 -> 11.
        upd(32'h0000_1000, 1'b1, 32'h0000_2000);
        upd(32'h0000_1000, 1'b1, 32'h0000_2000);
        lookup(32'h0000_1000);
        check_pred("gh_ff", 1'b1, 1'b1, 1'b1);
        check_eq("gh_ff_target", pred_target_o, 32'h0000_2000);
        // Eight not-taken updates at pc 0x40 clear GHR to 0x00, again avoiding idx 0x00/0xFF.
        for (int i = 0; i < 8; i++) upd(32'h0000_0040, 1'b0, 32'h0000_0800);
        // GHR=0x00: idx 0x00 still holds the reset counter 01.
        lookup(32'h0000_1000);
        check_pred("gh_00", 1'b1, 1'b1, 1'b0);
`else
        // Cold lookup.
        lookup(32'h0000_1000);
        check_pred("cold", 1'b1, 1'b0, 1'b0);
        @(negedge clk_i);
        check_eq("idle_valid", {31'd0, pred_valid_o}, 32'd0);

        // Two taken updates: counter 01 -> 10 -> 11, BTB allocated.
        upd(32'h0000_1000, 1'b1, 32'h0000_2000);
        upd(32'h0000_1000, 1'b1, 32'h0000_2000);
        lookup(32'h0000_1000);
        check_pred("trained", 1'b1, 1'b1, 1'b1);
        check_eq("trained_target", pred_target_o, 32'h0000_2000);

        // Saturate at 11, then one not-taken to 10.
        for (int i = 0; i < 3; i++) upd(32'h0000_1000, 1'b1, 32'h0000_2000);
        upd(32'h0000_1000, 1'b0, 32'h0000_0000);
        lookup(32'h0000_1000);
        check_pred("sat_hi", 1'b1, 1'b1, 1'b1);
        // 10 -> 01: predicts not taken, BTB untouched by not-taken updates.
        upd(32'h0000_1000, 1'b0, 32'h0000_0000);
        lookup(32'h0000_1000);
        check_pred("weak_nt", 1'b1, 1'b1, 1'b0);
        check_eq("weak_nt_target", pred_target_o, 32'h0000_2000);
        // 01 -> 00 -> 00 (saturate low), then taken to 01 and 10.
        upd(32'h0000_1000, 1'b0, 32'h0000_0000);
        upd(32'h0000_1000, 1'b0, 32'h0000_0000);
        upd(32'h0000_1000, 1'b1, 32'h0000_2000);
        lookup(32'h0000_1000);
        check_pred("sat_lo", 1'b1, 1'b1, 1'b0);
        upd(32'h0000_1000, 1'b1, 32'h0000_2000);
        lookup(32'h0000_1000);
        check_pred("recover", 1'b1, 1'b1, 1'b1);

        // Stall holds all outputs, with or without a lookup.
        stall_i = 1'b1;
        lookup(32'h0000_5000);
        check_pred("stall_lk", 1'b1, 1'b1, 1'b1);
        @(negedge clk_i);
        check_pred("stall_idle", 1'b1, 1'b1, 1'b1);
        check_eq("stall_target", pred_target_o, 32'h0000_2000);
        // Unstalled idle cycle drops only valid.
        stall_i = 1'b0;
        @(negedge clk_i);
        check_pred("drop_valid", 1'b0, 1'b1, 1'b1);
        check_eq("drop_target", pred_target_o, 32'h0000_2000);

        // Alias: 0x1100 shares BTB set 0 with 0x1000 and evicts it.
        upd(32'h0000_1100, 1'b1, 32'h0000_3000);
        lookup(32'h0000_1000);
        check_pred("alias_old", 1'b1, 1'b0, 1'b0);
        check_eq("alias_old_target", pred_target_o, 32'h0000_3000);
        lookup(32'h0000_1100);
        check_pred("alias_new", 1'b1, 1'b1, 1'b1);

        // Same-cycle lookup and first update at 0x4010: read-before-write.
        lookup_valid_i = 1'b1;
        pc_i           = 32'h0000_4010;
        upd(32'h0000_4010, 1'b1, 32'h0000_4444);
        lookup_valid_i = 1'b0;
        check_pred("rbw", 1'b1, 1'b0, 1'b0);
        lookup(32'h0000_4010);
        check_pred("rbw_next", 1'b1, 1'b1, 1'b1);
        check_eq("rbw_next_target", pred_target_o, 32'h0000_4444);

        // Asynchronous reset while stalled, with an update that must be discarded.
        stall_i = 1'b1;
        #2;
        rst_i        = 1'b0;
        upd_valid_i  = 1'b1;
        upd_pc_i     = 32'h0000_1000;
        upd_taken_i  = 1'b1;
        upd_target_i = 32'h0000_2000;
        #1;
        check_pred("async_rst", 1'b0, 1'b0, 1'b0);
        check_eq("async_rst_target", pred_target_o, 32'h0000_0000);
        @(negedge clk_i);
        rst_i       = 1'b1;
        upd_valid_i = 1'b0;
        stall_i     = 1'b0;
        lookup(32'h0000_1000);
        check_pred("post_rst", 1'b1, 1'b0, 1'b0);
        lookup(32'h0000_4010);
        check_pred("post_rst2", 1'b1, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
